// File: rtl/tbman.sv
// tbman: testbench-manager responder on the CPU data bus.
//
// Memory-mapped debug peripheral selected by cs_tbman_n. It provides an ID
// word, a free-running 64-bit cycle counter with a coherent LO/HI read, a
// console character FIFO drained through a valid/ready port, end-of-test
// exit/pass reporting and a watchdog that ends the run with TIMEOUT_CODE.
// It never touches data memory.
//
// Ports:
//   clk              in   rising-edge clock for all state
//   reset            in   synchronous, active-high
//   cs_tbman_n       in   chip select, active-low
//   wr_en            in   1 = write, 0 = read (qualified by chip select)
//   addr[7:0]        in   byte offset; addr[1:0] ignored
//   write_data[31:0] in   store data
//   read_data_tbman  out  load data, combinational in the access cycle
//   char_valid       out  console FIFO non-empty
//   char_data[7:0]   out  FIFO head byte
//   char_ready       in   console sink accepts the head byte
//   sim_done         out  sticky end-of-test flag
//   sim_pass         out  1 iff exit_code == 0 (meaningful once sim_done)
//   exit_code[31:0]  out  latched exit value
//
// Register map (word offsets):
//   0x00 ID  RO | 0x04 CYCLE_LO RO | 0x08 CYCLE_HI RO | 0x0C PUTC WO
//   0x10 STATUS RO [0]empty [1]full [2]overflow [3]sim_done [4]timeout
//                  [15:8]count | 0x14 EXIT WO | 0x18 WDOG RW
//
// Console handshake: a byte moves from the FIFO to the sink on every rising
// edge where char_valid && char_ready are both high. char_valid never drops
// and char_data never changes while char_valid is high and char_ready is low.

module tbman #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] ID_VALUE     = 32'h54424D4E,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD0001,
  // Value the cycle counter takes on reset; 0 in normal use.
  parameter logic [63:0] CYCLE_INIT   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_tbman_n,
  input  logic        wr_en,
  input  logic [7:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_tbman,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        sim_done,
  output logic        sim_pass,
  output logic [31:0] exit_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [5:0] A_ID     = 6'h00;
  localparam logic [5:0] A_LO     = 6'h01;
  localparam logic [5:0] A_HI     = 6'h02;
  localparam logic [5:0] A_PUTC   = 6'h03;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_EXIT   = 6'h05;
  localparam logic [5:0] A_WDOG   = 6'h06;

  logic [63:0]   cycle;
  logic [31:0]   hi_shadow;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          timeout;
  logic [31:0]   wdog;

  logic [5:0] word;
  logic       rd;
  logic       wr;
  logic       wr_putc;
  logic       wr_exit;
  logic       wr_wdog;
  logic       empty;
  logic       full;
  logic       do_pop;
  logic       do_push;
  logic       drop;
  logic       expire;
  logic       unused_addr;

  assign word        = addr[7:2];
  assign unused_addr = ^addr[1:0];
  assign rd          = !cs_tbman_n && !wr_en;
  assign wr          = !cs_tbman_n && wr_en;

  // EXIT and WDOG are frozen once the run has ended.
  assign wr_putc = wr && (word == A_PUTC);
  assign wr_exit = wr && (word == A_EXIT) && !sim_done;
  assign wr_wdog = wr && (word == A_WDOG) && !sim_done;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign char_valid = !empty;
  assign char_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the sink is draining.
  assign do_pop  = char_valid && char_ready;
  assign do_push = wr_putc && (!full || do_pop);
  assign drop    = wr_putc && full && !do_pop;

  // Expiry is the 1->0 step; a WDOG write in that cycle reloads instead.
  assign expire = (wdog == 32'd1) && !sim_done && !wr_wdog;

  always_comb begin
    read_data_tbman = '0;
    if (rd) begin
      case (word)
        A_ID:     read_data_tbman = ID_VALUE;
        A_LO:     read_data_tbman = cycle[31:0];
        A_HI:     read_data_tbman = hi_shadow;
        A_STATUS: read_data_tbman = {16'h0, 8'(count), 3'b000, timeout,
                                     sim_done, overflow, full, empty};
        A_WDOG:   read_data_tbman = wdog;
        default:  read_data_tbman = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle     <= CYCLE_INIT;
      hi_shadow <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      wdog      <= '0;
      sim_done  <= 1'b0;
      sim_pass  <= 1'b0;
      exit_code <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      // Reading LO freezes the upper half so a following HI read is coherent.
      if (rd && (word == A_LO)) hi_shadow <= cycle[63:32];

      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      if (drop) overflow <= 1'b1;

      if (wr_wdog)
        wdog <= write_data;
      else if ((wdog != '0) && !sim_done)
        wdog <= wdog - 32'd1;

      // An explicit EXIT beats a watchdog expiry in the same cycle.
      if (wr_exit) begin
        sim_done  <= 1'b1;
        sim_pass  <= (write_data == 32'd0);
        exit_code <= write_data;
      end else if (expire) begin
        sim_done  <= 1'b1;
        sim_pass  <= 1'b0;
        exit_code <= TIMEOUT_CODE;
        timeout   <= 1'b1;
      end
    end
  end

endmodule
